i2s_rx_deser: RTL and testbench
===============================

Name: i2s_rx_deser

Overview:
- Downstream of the I2S clock/frame generator (12 MHz sys_ck, 1 MHz sck, 64-sck stereo frame with ws low = left, ws high = right).
- Takes the generated sck/ws plus the MEMS mic sd line, and deserialises each slot MSB-first in standard I2S (one-bit-delayed) format.
- Presents left/right sample pairs to the consumer on a valid/ready handshake, with sticky overrun detection.
- Runs entirely in the sys_ck domain; sck/ws arrive as sys_ck-synchronous signals.

Parameters:
- DATA_W, 24, bits captured per slot (MSB-first); the remaining slot bits are ignored.
- SLOT_W, 32, sck periods per half-frame (one channel); DATA_W <= SLOT_W.

Ports:
- sys_ck  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  I2S bit clock from the generator (6 sys_ck high, 6 low).
- ws  in  1  I2S word select from the generator; 0 = left, 1 = right.
- sd  in  1  serial data from the mic; changes after sck falling edges.
- out_left  out  DATA_W  left sample of the current pair.
- out_right  out  DATA_W  right sample of the current pair.
- out_valid  out  1  pair available.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- overrun  out  1  sticky flag: a completed pair was dropped.
- overrun_clr  in  1  synchronous clear for overrun.

Behaviour:
- Reset (async assert, sync-to-sys_ck release): all outputs 0; internal sck_q, ws_prev, bit_idx, shift register, held left word, and synced state all cleared.
- Edge detect:
  - sck_q registers sck each cycle.
  - rise = sck & ~sck_q.
  - All sampling happens only on rise cycles; ws and sd are sampled in the same cycle.
- Bit tracking (on each rise):
  - If ws != ws_prev: this rise carries the last (delayed) bit of the previous slot, which is discarded. Then bit_idx <= 0, chan <= ws, ws_prev <= ws.
  - Else if bit_idx < DATA_W: shift <= {shift[DATA_W-2:0], sd}; bit_idx <= bit_idx + 1.
  - Else bit_idx increments, saturating at SLOT_W; sd is ignored.
  - bit_idx width is clog2(SLOT_W)+1.
- Word complete: on the rise where bit_idx == DATA_W-1 is captured, the full word is {shift[DATA_W-2:0], sd}.
- States:
  - UNSYNC (after reset): ignore all data until a ws 1->0 transition (start of a left slot) is seen, then go to LEFT.
  - LEFT: on left word complete, latch it into the held-left register and go to RIGHT.
  - RIGHT: on right word complete, form the pair (held-left, word) and go to LEFT.
  - A ws change before word complete (impossible with a correct generator) discards the partial word and moves to the state matching the new ws.
- Pair output:
  - out_left/out_right/out_valid update in the sys_ck cycle after the completing rise.
  - out_valid stays 1 until accepted; data is stable while valid and unaccepted.
  - Accept cycle with no new pair: out_valid <= 0; data regs keep their values.
  - New pair while out_valid && !out_ready: the pair is dropped, old data held, overrun <= 1.
  - New pair in the same cycle as an accept: the new pair is loaded, out_valid stays 1, no overrun.
- Overrun:
  - overrun_clr clears overrun; if overrun_clr coincides with a drop, the set wins.
- Rate: with the 12 MHz generator, one pair per 768 sys_ck cycles; the consumer has a full frame to accept before overrun.
- Reset mid-frame: everything returns to UNSYNC; the first pair after reset is emitted only after one complete left slot followed by its right slot.

Test Plan:
1. Reset held 20 cycles with sck/ws toggling -> out_left=0, out_right=0, out_valid=0, overrun=0. Still 0 through the first ws rise after release (UNSYNC).
2. Mic model sends left=0x123456, right=0xABCDEF, slot bits 24..31 = 1, out_ready=1 -> exactly one out_valid pulse per frame with 0x123456/0xABCDEF. The pulse occurs 1 cycle after the rise sampling right bit 23.
3. Left=0x800000, right=0x7FFFFF, then 0x000001/0xFFFFFF -> exact values. This confirms MSB-first order, the one-bit delay, and no influence from the ignored bits.
4. rst_n released mid-right-slot -> no pair for the partial frame; the first pair equals the next full frame's values.
5. out_ready=0 across two frames (A, then B) -> out holds A, overrun=1 after B completes. Then out_ready=1 -> A accepted, out_valid=0. Then overrun_clr -> overrun=0.
6. out_ready asserted exactly in the cycle pair C completes while B is valid -> B accepted, C loaded, out_valid stays 1, overrun unchanged. Then rst_n pulsed mid-left-slot -> all outputs 0 and resync per scenario 4.

Source files
------------

// File: rtl/i2s_rx_deser_if.sv
// Bundle for the I2S receiver: serial inputs from generator/mic plus the
// sample-pair handshake toward the consumer.
interface i2s_rx_deser_if #(
  parameter int DATA_W = 24
) ();
  logic              sck;
  logic              ws;
  logic              sd;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;
  logic              overrun_clr;

  modport master (
    input  sck, ws, sd, out_ready, overrun_clr,
    output out_left, out_right, out_valid, overrun
  );

  modport slave (
    output sck, ws, sd, out_ready, overrun_clr,
    input  out_left, out_right, out_valid, overrun
  );
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S receiver: deserialises standard (one-bit-delayed) MSB-first slots in the
// sys_ck domain and hands out left/right pairs with sticky overrun detection.
module i2s_rx_deser #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic           sys_ck,
  input  logic           rst_n,
  i2s_rx_deser_if.master bus
);
  localparam int IDX_W = $clog2(SLOT_W) + 1;

  typedef enum logic [1:0] {UNSYNC, LEFT, RIGHT} state_e;

  state_e            state_q, state_d;
  logic              sck_q;
  logic              ws_prev_q, ws_prev_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] held_left_q, held_left_d;
  logic [DATA_W-1:0] out_left_q, out_left_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  logic              rise;
  logic              ws_chg;
  logic              word_done;
  logic              pair_new;
  logic              drop;
  logic [DATA_W-1:0] word;

  assign rise      = bus.sck & ~sck_q;
  assign ws_chg    = rise & (bus.ws != ws_prev_q);
  assign word      = {shift_q[DATA_W-2:0], bus.sd};
  assign word_done = rise & ~ws_chg & (bit_idx_q == IDX_W'(DATA_W - 1));
  assign pair_new  = word_done & (state_q == RIGHT);
  assign drop      = pair_new & out_valid_q & ~bus.out_ready;

  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    held_left_d = held_left_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (rise) begin
      if (ws_chg) begin
        // This rise carries the previous slot's delayed last bit; drop it.
        bit_idx_d = '0;
        ws_prev_d = bus.ws;
        if (state_q == UNSYNC) begin
          if (ws_prev_q && !bus.ws) state_d = LEFT;
        end else begin
          state_d = bus.ws ? RIGHT : LEFT;
        end
      end else if (bit_idx_q < IDX_W'(DATA_W)) begin
        shift_d   = word;
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end else if (bit_idx_q < IDX_W'(SLOT_W)) begin
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
    end

    if (word_done) begin
      case (state_q)
        LEFT: begin
          held_left_d = word;
          state_d     = RIGHT;
        end
        RIGHT:   state_d = LEFT;
        default: ;
      endcase
    end

    if (pair_new && !drop) begin
      out_left_d  = held_left_q;
      out_right_d = word;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (drop)                 overrun_d = 1'b1;
    else if (bus.overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge sys_ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNSYNC;
      sck_q       <= 1'b0;
      ws_prev_q   <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      held_left_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= bus.sck;
      ws_prev_q   <= ws_prev_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      held_left_q <= held_left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_left  = out_left_q;
  assign bus.out_right = out_right_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: an I2S mic/generator model drives frames,
// a pair-level handshake model predicts outputs and is compared every cycle.
module tb_i2s_rx_deser;
  localparam int DATA_W = 24;
  localparam int SLOT_W = 32;

  logic sys_ck = 1'b0;
  logic rst_n  = 1'b0;

  i2s_rx_deser_if #(.DATA_W(DATA_W)) bus ();

  i2s_rx_deser #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
    .sys_ck (sys_ck),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sys_ck = ~sys_ck;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  // Pair-level model: the stimulus announces each completed pair via pair_stb.
  logic              pair_stb = 1'b0;
  logic [DATA_W-1:0] stb_l = '0, stb_r = '0;
  logic [DATA_W-1:0] m_left, m_right;
  logic              m_valid, m_ovr;
  logic              prev_bit = 1'b1;

  always @(posedge sys_ck or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= '0;
      m_right <= '0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      if (pair_stb) begin
        if (m_valid && !bus.out_ready) m_ovr <= 1'b1;
        else begin
          m_left  <= stb_l;
          m_right <= stb_r;
          m_valid <= 1'b1;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid <= 1'b0;
      end
      if (!(pair_stb && m_valid && !bus.out_ready) && bus.overrun_clr) m_ovr <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_ck) begin
    chk("cycle", {14'd0, bus.out_valid, bus.overrun, bus.out_left, bus.out_right},
                 {14'd0, m_valid, m_ovr, m_left, m_right});
    if (bus.out_valid) vcount++;
  end

  // One 64-sck stereo frame. rel_at/rst_at are sck indices for reset release /
  // reset pulse (-1 = none); n=56 is the rise carrying right bit 23.
  task automatic frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                       input bit exp_pair, input int rel_at, input int rst_at,
                       input bit rdy_at_done);
    logic [31:0] sl, sr;
    sl = {l, 8'hFF};
    sr = {r, 8'hFF};
    for (int n = 0; n < 64; n++) begin
      @(negedge sys_ck);
      if (n == rst_at) rst_n = 1'b0;
      if (n == rel_at) rst_n = 1'b1;
      bus.sck = 1'b0;
      bus.ws  = (n >= 32);
      bus.sd  = prev_bit;
      prev_bit = (n < 32) ? sl[31-n] : sr[63-n];
      repeat (5) @(negedge sys_ck);
      bus.sck = 1'b1;
      if (n == 56 && exp_pair) begin
        pair_stb = 1'b1;
        stb_l = l;
        stb_r = r;
      end
      if (n == 56 && rdy_at_done) bus.out_ready = 1'b1;
      @(negedge sys_ck);
      pair_stb = 1'b0;
      if (n == 56 && rdy_at_done) bus.out_ready = 1'b0;
      if (n == rst_at) rst_n = 1'b1;
      repeat (5) @(negedge sys_ck);
    end
  endtask

  task automatic pair_is(input string name, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    chk({name, "_left"}, 64'(bus.out_left), 64'(l));
    chk({name, "_right"}, 64'(bus.out_right), 64'(r));
  endtask

  initial begin
    bus.sck = 1'b0; bus.ws = 1'b0; bus.sd = 1'b0;
    bus.out_ready = 1'b1; bus.overrun_clr = 1'b0;

    // 1: reset with toggling clocks, then one unsynced frame
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_ck);
      bus.sck = ((i / 6) % 2) == 1;
      bus.ws  = ((i / 12) % 2) == 1;
    end
    chk("rst_outputs", {bus.out_valid, bus.overrun, bus.out_left, bus.out_right}, '0);
    @(negedge sys_ck);
    bus.sck = 1'b0; bus.ws = 1'b0;
    rst_n = 1'b1;
    vcount = 0;
    frame(24'h123456, 24'hABCDEF, 1'b0, -1, -1, 1'b0);
    chk("unsync_quiet", {bus.out_valid, bus.overrun, bus.out_left, bus.out_right}, '0);
    chk("unsync_vcount", 64'(vcount), 64'd0);

    // 2: steady frames, one valid pulse each
    vcount = 0;
    frame(24'h123456, 24'hABCDEF, 1'b1, -1, -1, 1'b0);
    frame(24'h123456, 24'hABCDEF, 1'b1, -1, -1, 1'b0);
    chk("pulses", 64'(vcount), 64'd2);
    pair_is("basic", 24'h123456, 24'hABCDEF);

    // 3: bit order and extremes
    frame(24'h800000, 24'h7FFFFF, 1'b1, -1, -1, 1'b0);
    pair_is("msb", 24'h800000, 24'h7FFFFF);
    frame(24'h000001, 24'hFFFFFF, 1'b1, -1, -1, 1'b0);
    pair_is("lsb", 24'h000001, 24'hFFFFFF);

    // 4: release mid-right-slot
    @(negedge sys_ck);
    rst_n = 1'b0;
    frame(24'h111111, 24'h222222, 1'b0, 40, -1, 1'b0);
    chk("partial_quiet", {bus.out_valid, bus.out_left, bus.out_right}, '0);
    frame(24'h5A5A5A, 24'hA5A5A5, 1'b1, -1, -1, 1'b0);
    pair_is("resync", 24'h5A5A5A, 24'hA5A5A5);

    // 5: backpressure and overrun
    bus.out_ready = 1'b0;
    frame(24'h111111, 24'h222222, 1'b1, -1, -1, 1'b0);
    frame(24'h333333, 24'h444444, 1'b1, -1, -1, 1'b0);
    pair_is("held_a", 24'h111111, 24'h222222);
    chk("ovr_set", {bus.out_valid, bus.overrun}, 2'b11);
    bus.out_ready = 1'b1;
    @(negedge sys_ck);
    bus.out_ready = 1'b0;
    chk("accepted", {bus.out_valid, bus.overrun}, 2'b01);
    pair_is("kept_a", 24'h111111, 24'h222222);
    bus.overrun_clr = 1'b1;
    @(negedge sys_ck);
    bus.overrun_clr = 1'b0;
    chk("ovr_clr", 64'(bus.overrun), 64'd0);

    // 6: accept coinciding with a new pair, then reset mid-left-slot
    frame(24'h555555, 24'h666666, 1'b1, -1, -1, 1'b0);
    frame(24'h777777, 24'h888888, 1'b1, -1, -1, 1'b1);
    pair_is("swap_c", 24'h777777, 24'h888888);
    chk("swap_flags", {bus.out_valid, bus.overrun}, 2'b10);
    bus.out_ready = 1'b1;
    frame(24'h999999, 24'hAAAAAA, 1'b0, -1, 10, 1'b0);
    chk("pulse_quiet", {bus.out_valid, bus.overrun, bus.out_left, bus.out_right}, '0);
    frame(24'hC0FFEE, 24'h0BADF0, 1'b1, -1, -1, 1'b0);
    pair_is("after_pulse", 24'hC0FFEE, 24'h0BADF0);

    repeat (4) @(negedge sys_ck);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
